pma_region_table: RTL and testbench

Runtime-programmable physical memory attribute (PMA) table for the CVA6 core. It replaces the fixed execute, cached and non-idempotent region rules of the static configuration with NrRegions writable entries, each carrying a base, a length and attribute bits. Writes are staged in shadow registers and become visible atomically on commit. NrPorts independent lookup ports (fetch, load/store, PTW) each return registered attributes one cycle after the request.

---
 rtl/pma_region_table.sv | 214 +++++++++++++++++++++
 tb/tb_pma_region_table.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pma_region_table.sv
// Runtime-programmable PMA region table. Writes go to shadow entries and a commit
// makes them active; each lookup port returns registered attributes one cycle later.
module pma_region_table #(
  parameter int unsigned NrRegions = 4,
  parameter int unsigned NrPorts   = 2,
  parameter int unsigned AddrWidth = 64,
  parameter logic [NrRegions*AddrWidth-1:0] RstBase   = '0,
  parameter logic [NrRegions*AddrWidth-1:0] RstLength = '0,
  parameter logic [NrRegions*5-1:0]         RstAttr   = '0,
  localparam int unsigned IdxW = (NrRegions > 1) ? $clog2(NrRegions) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cfg_valid_i,
  input  logic                         cfg_we_i,
  input  logic [IdxW-1:0]              cfg_idx_i,
  input  logic [1:0]                   cfg_field_i,
  input  logic [AddrWidth-1:0]         cfg_wdata_i,
  input  logic                         cfg_commit_i,
  output logic                         cfg_rvalid_o,
  output logic [AddrWidth-1:0]         cfg_rdata_o,
  output logic                         cfg_err_o,
  input  logic [NrPorts-1:0]           req_valid_i,
  input  logic [NrPorts*AddrWidth-1:0] req_addr_i,
  output logic [NrPorts-1:0]           resp_valid_o,
  output logic [NrPorts-1:0]           resp_hit_o,
  output logic [NrPorts-1:0]           resp_exec_o,
  output logic [NrPorts-1:0]           resp_cached_o,
  output logic [NrPorts-1:0]           resp_nonidem_o
);

  localparam int unsigned AttrV = 0;
  localparam int unsigned AttrX = 1;
  localparam int unsigned AttrC = 2;
  localparam int unsigned AttrN = 3;
  localparam int unsigned AttrL = 4;

  localparam logic [1:0] FldBase = 2'd0;
  localparam logic [1:0] FldLen  = 2'd1;
  localparam logic [1:0] FldAttr = 2'd2;
  localparam logic [1:0] FldRsvd = 2'd3;

  logic [AddrWidth-1:0] r_sh_base  [NrRegions];
  logic [AddrWidth-1:0] r_sh_len   [NrRegions];
  logic [4:0]           r_sh_attr  [NrRegions];
  logic [AddrWidth-1:0] r_act_base [NrRegions];
  logic [AddrWidth-1:0] r_act_len  [NrRegions];
  logic [4:0]           r_act_attr [NrRegions];

  logic                 r_cfg_rvalid_p1;
  logic                 r_cfg_err_p1;
  logic [AddrWidth-1:0] r_cfg_rdata_p1;

  logic [NrPorts-1:0]   r_resp_vld_p1;
  logic [NrPorts-1:0]   r_resp_hit_p1;
  logic [NrPorts-1:0]   r_resp_exec_p1;
  logic [NrPorts-1:0]   r_resp_cached_p1;
  logic [NrPorts-1:0]   r_resp_nonidem_p1;

  logic [(2**IdxW)-1:0] w_lock_vec;
  logic                 w_idx_ok;
  logic                 w_fld_ok;
  logic                 w_locked;
  logic                 w_cfg_bad;
  logic                 w_wr_ok;
  logic                 w_rd_ok;
  logic [AddrWidth-1:0] w_rd_data;

  logic [AddrWidth-1:0] w_addr [NrPorts];
  logic [NrPorts-1:0]   w_hit;
  logic [NrPorts-1:0]   w_exec;
  logic [NrPorts-1:0]   w_cached;
  logic [NrPorts-1:0]   w_nonidem;

  // Unsigned containment test; offset is only meaningful once addr >= base.
  function automatic logic in_region(input logic [AddrWidth-1:0] addr,
                                     input logic [AddrWidth-1:0] base,
                                     input logic [AddrWidth-1:0] len);
    return (addr >= base) && ((addr - base) < len);
  endfunction

  // Stage p0: configuration decode against the current shadow/active state.
  always_comb begin
    w_lock_vec = '0;
    for (int i = 0; i < NrRegions; i++) begin
      w_lock_vec[i] = r_act_attr[i][AttrL];
    end
  end

  assign w_idx_ok  = (32'(cfg_idx_i) < NrRegions);
  assign w_fld_ok  = (cfg_field_i != FldRsvd);
  assign w_locked  = w_lock_vec[cfg_idx_i];
  assign w_cfg_bad = !w_idx_ok || !w_fld_ok || (cfg_we_i && w_locked);
  assign w_wr_ok   = cfg_valid_i && cfg_we_i && !w_cfg_bad;
  assign w_rd_ok   = cfg_valid_i && !cfg_we_i && !w_cfg_bad;

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NrRegions; i++) begin
      if (cfg_idx_i == IdxW'(i)) begin
        case (cfg_field_i)
          FldBase: w_rd_data = r_sh_base[i];
          FldLen:  w_rd_data = r_sh_len[i];
          FldAttr: w_rd_data = AddrWidth'(r_sh_attr[i]);
          default: w_rd_data = '0;
        endcase
      end
    end
  end

  // Commit reads the pre-write shadow; a same-cycle write then overrides the shadow only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NrRegions; i++) begin
        r_sh_base[i]  <= RstBase[i*AddrWidth +: AddrWidth];
        r_sh_len[i]   <= RstLength[i*AddrWidth +: AddrWidth];
        r_sh_attr[i]  <= RstAttr[i*5 +: 5];
        r_act_base[i] <= RstBase[i*AddrWidth +: AddrWidth];
        r_act_len[i]  <= RstLength[i*AddrWidth +: AddrWidth];
        r_act_attr[i] <= RstAttr[i*5 +: 5];
      end
    end else begin
      for (int i = 0; i < NrRegions; i++) begin
        if (cfg_commit_i) begin
          if (r_act_attr[i][AttrL]) begin
            r_sh_base[i] <= r_act_base[i];
            r_sh_len[i]  <= r_act_len[i];
            r_sh_attr[i] <= r_act_attr[i];
          end else begin
            r_act_base[i] <= r_sh_base[i];
            r_act_len[i]  <= r_sh_len[i];
            r_act_attr[i] <= r_sh_attr[i];
          end
        end
        if (w_wr_ok && (cfg_idx_i == IdxW'(i))) begin
          case (cfg_field_i)
            FldBase: r_sh_base[i] <= cfg_wdata_i;
            FldLen:  r_sh_len[i]  <= cfg_wdata_i;
            FldAttr: r_sh_attr[i] <= cfg_wdata_i[4:0];
            default: ;
          endcase
        end
      end
    end
  end

  // Stage p1: registered configuration response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cfg_rvalid_p1 <= 1'b0;
      r_cfg_err_p1    <= 1'b0;
      r_cfg_rdata_p1  <= '0;
    end else begin
      r_cfg_rvalid_p1 <= cfg_valid_i && !w_cfg_bad;
      r_cfg_err_p1    <= cfg_valid_i && w_cfg_bad;
      if (w_rd_ok) begin
        r_cfg_rdata_p1 <= w_rd_data;
      end
    end
  end

  // Stage p0: per-port lookup against the active copy, lowest index wins.
  for (genvar p = 0; p < NrPorts; p++) begin : g_addr
    assign w_addr[p] = req_addr_i[p*AddrWidth +: AddrWidth];
  end

  always_comb begin
    w_hit     = '0;
    w_exec    = '0;
    w_cached  = '0;
    w_nonidem = '1;
    for (int p = 0; p < NrPorts; p++) begin
      for (int i = int'(NrRegions) - 1; i >= 0; i--) begin
        if (r_act_attr[i][AttrV] && in_region(w_addr[p], r_act_base[i], r_act_len[i])) begin
          w_hit[p]     = 1'b1;
          w_exec[p]    = r_act_attr[i][AttrX];
          w_cached[p]  = r_act_attr[i][AttrC];
          w_nonidem[p] = r_act_attr[i][AttrN];
        end
      end
    end
  end

  // Stage p1: registered lookup response; attributes hold while no request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_resp_vld_p1     <= '0;
      r_resp_hit_p1     <= '0;
      r_resp_exec_p1    <= '0;
      r_resp_cached_p1  <= '0;
      r_resp_nonidem_p1 <= '0;
    end else begin
      r_resp_vld_p1 <= req_valid_i;
      for (int p = 0; p < NrPorts; p++) begin
        if (req_valid_i[p]) begin
          r_resp_hit_p1[p]     <= w_hit[p];
          r_resp_exec_p1[p]    <= w_exec[p];
          r_resp_cached_p1[p]  <= w_cached[p];
          r_resp_nonidem_p1[p] <= w_nonidem[p];
        end
      end
    end
  end

  assign cfg_rvalid_o   = r_cfg_rvalid_p1;
  assign cfg_err_o      = r_cfg_err_p1;
  assign cfg_rdata_o    = r_cfg_rdata_p1;
  assign resp_valid_o   = r_resp_vld_p1;
  assign resp_hit_o     = r_resp_hit_p1;
  assign resp_exec_o    = r_resp_exec_p1;
  assign resp_cached_o  = r_resp_cached_p1;
  assign resp_nonidem_o = r_resp_nonidem_p1;

endmodule

// File: tb/tb_pma_region_table.sv
// Bench for pma_region_table: a table-level model predicts every response cycle,
// with directed scenarios pinned by hand-computed literal expectations.
module tb_pma_region_table;
  localparam int NR = 3;
  localparam int NP = 2;
  localparam int AW = 64;
  localparam logic [NR*AW-1:0] RB = {64'h8000_0000, 64'h1_0000, 64'h0};
  localparam logic [NR*AW-1:0] RL = {64'h4000_0000, 64'h1_0000, 64'h1000};
  localparam logic [NR*5-1:0]  RA = {5'h07, 5'h03, 5'h03};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_valid, cfg_we, cfg_commit;
  logic [1:0] cfg_idx, cfg_field;
  logic [AW-1:0] cfg_wdata;
  logic cfg_rvalid, cfg_err;
  logic [AW-1:0] cfg_rdata;
  logic [NP-1:0] req_valid;
  logic [NP*AW-1:0] req_addr;
  logic [NP-1:0] resp_valid, resp_hit, resp_exec, resp_cached, resp_nonidem;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  logic [AW-1:0] sb[NR], sl[NR], ab[NR], al[NR];
  logic [4:0] sa[NR], aa[NR];
  logic exp_rv, exp_err;
  logic [AW-1:0] exp_rd;
  logic [NP-1:0] exp_vld, exp_hit, exp_x, exp_c, exp_n;

  pma_region_table #(
    .NrRegions(NR), .NrPorts(NP), .AddrWidth(AW),
    .RstBase(RB), .RstLength(RL), .RstAttr(RA)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_valid_i(cfg_valid), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx),
    .cfg_field_i(cfg_field), .cfg_wdata_i(cfg_wdata), .cfg_commit_i(cfg_commit),
    .cfg_rvalid_o(cfg_rvalid), .cfg_rdata_o(cfg_rdata), .cfg_err_o(cfg_err),
    .req_valid_i(req_valid), .req_addr_i(req_addr),
    .resp_valid_o(resp_valid), .resp_hit_o(resp_hit), .resp_exec_o(resp_exec),
    .resp_cached_o(resp_cached), .resp_nonidem_o(resp_nonidem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [AW-1:0] got, input logic [AW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
    end
  endtask

  task automatic model_reset();
    logic [NR*AW-1:0] rb_v, rl_v;
    logic [NR*5-1:0] ra_v;
    rb_v = RB; rl_v = RL; ra_v = RA;
    for (int i = 0; i < NR; i++) begin
      sb[i] = rb_v[i*AW +: AW]; ab[i] = rb_v[i*AW +: AW];
      sl[i] = rl_v[i*AW +: AW]; al[i] = rl_v[i*AW +: AW];
      sa[i] = ra_v[i*5 +: 5];   aa[i] = ra_v[i*5 +: 5];
    end
    exp_rv = 0; exp_err = 0; exp_rd = '0;
    exp_vld = '0; exp_hit = '0; exp_x = '0; exp_c = '0; exp_n = '0;
  endtask

  // Returns {hit, exec, cached, nonidem}: first valid region containing the address.
  function automatic logic [3:0] model_lookup(input logic [AW-1:0] a);
    for (int i = 0; i < NR; i++) begin
      if (aa[i][0] && a >= ab[i] && (a - ab[i]) < al[i])
        return {1'b1, aa[i][1], aa[i][2], aa[i][3]};
    end
    return 4'b0001;
  endfunction

  // Predicts the response to the inputs currently driven, then advances one clock.
  task automatic tick();
    logic [AW-1:0] nsb[NR], nsl[NR], nab[NR], nal[NR];
    logic [4:0] nsa[NR], naa[NR];
    logic n_rv, n_err, bad;
    logic [AW-1:0] n_rd;
    logic [NP-1:0] n_vld, n_hit, n_x, n_c, n_n;
    logic [3:0] r;
    int ix;
    nsb = sb; nsl = sl; nsa = sa; nab = ab; nal = al; naa = aa;
    n_rd = exp_rd; n_hit = exp_hit; n_x = exp_x; n_c = exp_c; n_n = exp_n;
    ix = int'(cfg_idx);
    bad = (ix >= NR) || (cfg_field == 2'd3);
    if (!bad && cfg_we) begin
      if (aa[ix][4]) bad = 1'b1;
    end
    n_rv = cfg_valid && !bad;
    n_err = cfg_valid && bad;
    if (cfg_valid && !cfg_we && !bad) begin
      case (cfg_field)
        2'd0: n_rd = sb[ix];
        2'd1: n_rd = sl[ix];
        default: n_rd = {59'd0, sa[ix]};
      endcase
    end
    if (cfg_commit) begin
      for (int i = 0; i < NR; i++) begin
        if (aa[i][4]) begin nsb[i] = ab[i]; nsl[i] = al[i]; nsa[i] = aa[i]; end
        else begin nab[i] = sb[i]; nal[i] = sl[i]; naa[i] = sa[i]; end
      end
    end
    if (cfg_valid && cfg_we && !bad) begin
      case (cfg_field)
        2'd0: nsb[ix] = cfg_wdata;
        2'd1: nsl[ix] = cfg_wdata;
        default: nsa[ix] = cfg_wdata[4:0];
      endcase
    end
    for (int p = 0; p < NP; p++) begin
      n_vld[p] = req_valid[p];
      if (req_valid[p]) begin
        r = model_lookup(req_addr[p*AW +: AW]);
        n_hit[p] = r[3]; n_x[p] = r[2]; n_c[p] = r[1]; n_n[p] = r[0];
      end
    end
    @(posedge clk); #1;
    sb = nsb; sl = nsl; sa = nsa; ab = nab; al = nal; aa = naa;
    exp_rv = n_rv; exp_err = n_err; exp_rd = n_rd;
    exp_vld = n_vld; exp_hit = n_hit; exp_x = n_x; exp_c = n_c; exp_n = n_n;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cfg_rvalid", cfg_rvalid, exp_rv);
      chk("cfg_err", cfg_err, exp_err);
      chk("cfg_rdata", cfg_rdata, exp_rd);
      chk("resp_valid", resp_valid, exp_vld);
      chk("resp_hit", resp_hit, exp_hit);
      chk("resp_exec", resp_exec, exp_x);
      chk("resp_cached", resp_cached, exp_c);
      chk("resp_nonidem", resp_nonidem, exp_n);
    end
  end

  task automatic idle_in();
    cfg_valid = 0; cfg_we = 0; cfg_idx = 0; cfg_field = 0; cfg_wdata = '0;
    cfg_commit = 0; req_valid = '0; req_addr = '0;
  endtask

  task automatic cfg(input logic we, input logic [1:0] idx, input logic [1:0] fld,
                     input logic [AW-1:0] d, input logic cm);
    cfg_valid = 1; cfg_we = we; cfg_idx = idx; cfg_field = fld; cfg_wdata = d; cfg_commit = cm;
    tick();
    idle_in();
  endtask

  task automatic commit();
    cfg_commit = 1;
    tick();
    idle_in();
  endtask

  task automatic look(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    req_valid = 2'b11; req_addr = {a1, a0};
    tick();
    idle_in();
  endtask

  task automatic chk_port(input string nm, input int p, input logic [3:0] hxcn);
    chk({nm, "_vld"}, resp_valid[p], 1);
    chk({nm, "_hit"}, resp_hit[p], hxcn[3]);
    chk({nm, "_exec"}, resp_exec[p], hxcn[2]);
    chk({nm, "_cached"}, resp_cached[p], hxcn[1]);
    chk({nm, "_nonidem"}, resp_nonidem[p], hxcn[0]);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rvalid"}, cfg_rvalid, 0);
    chk({nm, "_err"}, cfg_err, 0);
    chk({nm, "_rdata"}, cfg_rdata, 0);
    chk({nm, "_vld"}, resp_valid, 0);
    chk({nm, "_hit"}, resp_hit, 0);
    chk({nm, "_nonidem"}, resp_nonidem, 0);
  endtask

  initial begin
    logic [AW-1:0] pool[6];
    pool[0] = 64'h0; pool[1] = 64'h5000; pool[2] = 64'h8000_0000;
    pool[3] = 64'hBFFF_FFF0; pool[4] = 64'hC000_0000; pool[5] = 64'h1_0000;
    idle_in();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1;
    cmp_en = 1;

    look(64'h8000_0010, 64'hC000_0000);
    chk_port("rst_p0", 0, 4'b1110);
    chk_port("rst_p1", 1, 4'b0001);
    tick();
    chk("vld_drop", resp_valid, 0);
    chk("hold_hit", resp_hit, 2'b01);

    look(64'hBFFF_FFFF, 64'h1000);
    chk_port("bnd_last", 0, 4'b1110);
    chk_port("bnd_end", 1, 4'b0001);
    look(64'hFFF, 64'h1_FFFF);
    chk_port("e0_last", 0, 4'b1100);
    chk_port("e1_last", 1, 4'b1100);

    cfg(1, 2'd1, 2'd0, 64'h2000, 0);
    chk("wr_rvalid", cfg_rvalid, 1);
    chk("wr_err", cfg_err, 0);
    cfg(1, 2'd1, 2'd1, 64'h1000, 0);
    look(64'h1_0000, 64'h2000);
    chk_port("precommit_old", 0, 4'b1100);
    chk_port("precommit_new", 1, 4'b0001);
    cfg(0, 2'd1, 2'd0, 64'h0, 0);
    chk("rd_shadow", cfg_rdata, 64'h2000);
    chk("rd_rvalid", cfg_rvalid, 1);
    commit();
    look(64'h1_0000, 64'h2000);
    chk_port("commit_old", 0, 4'b0001);
    chk_port("commit_new", 1, 4'b1100);

    cfg(1, 2'd3, 2'd0, 64'h55, 0);
    chk("idx_err", cfg_err, 1);
    chk("idx_rvalid", cfg_rvalid, 0);
    tick();
    chk("err_pulse", cfg_err, 0);
    cfg(0, 2'd0, 2'd3, 64'h0, 0);
    chk("fld_err", cfg_err, 1);

    cfg(1, 2'd0, 2'd1, 64'h100, 0);
    cfg(1, 2'd0, 2'd2, 64'h01, 0);
    cfg(1, 2'd1, 2'd0, 64'h0, 0);
    commit();
    look(64'h80, 64'h200);
    chk_port("ovl_low", 0, 4'b1000);
    chk_port("ovl_high", 1, 4'b1100);

    cfg(1, 2'd1, 2'd0, 64'h5000, 1);
    look(64'h200, 64'h5000);
    chk_port("wc_old", 0, 4'b1100);
    chk_port("wc_new", 1, 4'b0001);
    commit();
    look(64'h200, 64'h5000);
    chk_port("wc2_old", 0, 4'b0001);
    chk_port("wc2_new", 1, 4'b1100);

    cfg(1, 2'd0, 2'd2, 64'h11, 0);
    cfg(1, 2'd0, 2'd1, 64'h80, 1);
    chk("lockcommit_rvalid", cfg_rvalid, 1);
    cfg(0, 2'd0, 2'd1, 64'h0, 0);
    chk("lock_sh_pending", cfg_rdata, 64'h80);
    look(64'h80, 64'h90);
    chk_port("lock_p0", 0, 4'b1000);
    chk_port("lock_p1", 1, 4'b1000);
    commit();
    cfg(0, 2'd0, 2'd1, 64'h0, 0);
    chk("lock_reload", cfg_rdata, 64'h100);
    cfg(1, 2'd0, 2'd1, 64'h0, 0);
    chk("lock_wr_err", cfg_err, 1);
    chk("lock_wr_rvalid", cfg_rvalid, 0);
    cfg(0, 2'd0, 2'd1, 64'h0, 0);
    chk("lock_sh_kept", cfg_rdata, 64'h100);
    commit();
    look(64'h80, 64'hFF);
    chk_port("lock_keep0", 0, 4'b1000);
    chk_port("lock_keep1", 1, 4'b1000);

    cfg(1, 2'd2, 2'd2, 64'h09, 0);
    commit();
    look(64'h8000_0000, 64'hBFFF_FFFF);
    chk_port("ni_p0", 0, 4'b1001);
    chk_port("ni_p1", 1, 4'b1001);
    tick();
    chk("ni_hold", resp_nonidem, 2'b11);

    cfg(1, 2'd1, 2'd1, 64'h0, 0);
    commit();
    look(64'h5000, 64'h5FFF);
    chk_port("len0_p0", 0, 4'b0001);
    chk_port("len0_p1", 1, 4'b0001);

    for (int k = 0; k < 40; k++) begin
      req_valid = 2'($urandom_range(0, 3));
      req_addr = {pool[$urandom_range(0, 5)] + 64'($urandom_range(0, 16)),
                  pool[$urandom_range(0, 5)] + 64'($urandom_range(0, 16))};
      cfg_commit = ($urandom_range(0, 7) == 0);
      tick();
      idle_in();
    end

    cfg(1, 2'd1, 2'd0, 64'h7000, 0);
    cmp_en = 0;
    req_valid = 2'b11; req_addr = {64'h80, 64'h80};
    cfg_valid = 1; cfg_we = 0; cfg_idx = 2'd1; cfg_field = 2'd0;
    #2 rst_n = 0;
    #1;
    chk_zero("midrst");
    @(posedge clk); #1;
    chk("midrst_drop_vld", resp_valid, 0);
    chk("midrst_drop_rv", cfg_rvalid, 0);
    idle_in();
    rst_n = 1;
    model_reset();
    cmp_en = 1;
    look(64'h80, 64'h1_0000);
    chk_port("reload_p0", 0, 4'b1100);
    chk_port("reload_p1", 1, 4'b1100);
    cfg(0, 2'd1, 2'd0, 64'h0, 0);
    chk("reload_sh", cfg_rdata, 64'h1_0000);
    cfg(1, 2'd0, 2'd2, 64'h03, 0);
    chk("unlock_rvalid", cfg_rvalid, 1);
    tick();

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
